// File: rtl/kc_tap_loader.sv
// kc_tap_loader: KC85 TAP file loader between the hps_io ioctl port and the memory write arbiter.
// Optional macro TAP_AUTOSTART_EN adds exec_req/exec_addr for autostart. Rev 1.0
`default_nettype none

module kc_tap_loader #(
  parameter logic [7:0] TAP_INDEX = 8'd1,
  parameter bit         SIG_CHECK = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr_req,
  input  logic        mem_wr_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] load_addr,
  output logic [15:0] end_addr
`ifdef TAP_AUTOSTART_EN
  ,
  output logic        exec_req,
  output logic [15:0] exec_addr
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SIG, S_HDR, S_DATA, S_WRITE, S_FIN, S_DONE, S_ERR
  } state_t;

  state_t      state_q;
  logic        dl_q;
  logic [3:0]  sig_cnt_q;
  logic [7:0]  blk_pos_q;
  logic [7:0]  arg_cnt_q;
  logic [15:0] load_q;
  logic [15:0] end_q;
  logic [15:0] wr_ptr_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_data_q;
  logic        req_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
`ifdef TAP_AUTOSTART_EN
  logic [15:0] start_q;
  logic [15:0] exec_addr_q;
  logic        exec_req_q;
`endif

  logic        dl_d;
  logic        rise_d;
  logic        acc_d;
  logic [7:0]  blk_pos_d;
  logic [15:0] wr_ptr_d;
  logic        unused_addr;

  assign dl_d      = ioctl_download && (ioctl_index == TAP_INDEX);
  assign rise_d    = dl_d && !dl_q;
  assign acc_d     = ioctl_wr && dl_d && (state_q != S_WRITE);
  assign blk_pos_d = (blk_pos_q == 8'd128) ? 8'd0 : blk_pos_q + 8'd1;
  assign wr_ptr_d  = wr_ptr_q + 16'd1;
  assign unused_addr = ^ioctl_addr;

  function automatic logic [7:0] sig_byte(input logic [3:0] k);
    case (k)
      4'd0:    sig_byte = 8'hC3;
      4'd1:    sig_byte = 8'h4B;  // K
      4'd2:    sig_byte = 8'h43;  // C
      4'd3:    sig_byte = 8'h2D;  // -
      4'd4:    sig_byte = 8'h54;  // T
      4'd5:    sig_byte = 8'h41;  // A
      4'd6:    sig_byte = 8'h50;  // P
      4'd7:    sig_byte = 8'h45;  // E
      4'd8:    sig_byte = 8'h20;
      4'd9:    sig_byte = 8'h62;  // b
      4'd10:   sig_byte = 8'h79;  // y
      4'd11:   sig_byte = 8'h20;
      4'd12:   sig_byte = 8'h41;  // A
      4'd13:   sig_byte = 8'h46;  // F
      4'd14:   sig_byte = 8'h2E;  // .
      default: sig_byte = 8'h20;
    endcase
  endfunction

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dl_q       <= 1'b0;
      sig_cnt_q  <= 4'd0;
      blk_pos_q  <= 8'd0;
      arg_cnt_q  <= 8'd0;
      load_q     <= 16'd0;
      end_q      <= 16'd0;
      wr_ptr_q   <= 16'd0;
      mem_addr_q <= 16'd0;
      mem_data_q <= 8'd0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef TAP_AUTOSTART_EN
      start_q     <= 16'd0;
      exec_addr_q <= 16'd0;
      exec_req_q  <= 1'b0;
`endif
    end else begin
      dl_q <= dl_d;
`ifdef TAP_AUTOSTART_EN
      exec_req_q <= 1'b0;
`endif
      // A new download restarts the parser unless a memory write is still outstanding.
      if (rise_d && state_q != S_WRITE) begin
        state_q   <= S_SIG;
        sig_cnt_q <= 4'd0;
        blk_pos_q <= 8'd0;
        req_q     <= 1'b0;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        error_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_SIG: begin
            if (!dl_d) begin
              state_q <= S_ERR; error_q <= 1'b1; busy_q <= 1'b0;
            end else if (acc_d) begin
              sig_cnt_q <= sig_cnt_q + 4'd1;
              if (SIG_CHECK && (ioctl_data != sig_byte(sig_cnt_q))) begin
                state_q <= S_ERR; error_q <= 1'b1; busy_q <= 1'b0;
              end else if (sig_cnt_q == 4'd15) begin
                state_q <= S_HDR;
              end
            end
          end
          S_HDR: begin
            if (!dl_d) begin
              state_q <= S_ERR; error_q <= 1'b1; busy_q <= 1'b0;
            end else if (acc_d) begin
              blk_pos_q <= blk_pos_d;
              // Block position is data offset + 1 (position 0 is the block number).
              case (blk_pos_q)
                8'd17: arg_cnt_q      <= ioctl_data;
                8'd18: load_q[7:0]    <= ioctl_data;
                8'd19: load_q[15:8]   <= ioctl_data;
                8'd20: end_q[7:0]     <= ioctl_data;
                8'd21: end_q[15:8]    <= ioctl_data;
`ifdef TAP_AUTOSTART_EN
                8'd22: start_q[7:0]   <= ioctl_data;
                8'd23: start_q[15:8]  <= ioctl_data;
`endif
                default: ;
              endcase
              if (blk_pos_q == 8'd128) begin
                if ((arg_cnt_q < 8'd2) || (end_q <= load_q)) begin
                  state_q <= S_ERR; error_q <= 1'b1; busy_q <= 1'b0;
                end else begin
                  wr_ptr_q <= load_q;
                  state_q  <= S_DATA;
                end
              end
            end
          end
          S_DATA: begin
            if (!dl_d) begin
              state_q <= S_ERR; error_q <= 1'b1; busy_q <= 1'b0;
            end else if (acc_d) begin
              blk_pos_q <= blk_pos_d;
              if (blk_pos_q != 8'd0) begin
                mem_data_q <= ioctl_data;
                mem_addr_q <= wr_ptr_q;
                req_q      <= 1'b1;
                state_q    <= S_WRITE;
              end
            end
          end
          S_WRITE: begin
            if (mem_wr_ack) begin
              req_q    <= 1'b0;
              wr_ptr_q <= wr_ptr_d;
              if (wr_ptr_d == end_q) begin
                state_q <= S_FIN;
              end else if (!dl_d) begin
                state_q <= S_ERR; error_q <= 1'b1; busy_q <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_FIN: begin
            if (!dl_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
`ifdef TAP_AUTOSTART_EN
              exec_addr_q <= start_q;
              exec_req_q  <= (arg_cnt_q >= 8'd3);
`endif
            end
          end
          S_DONE: state_q <= S_IDLE;
          S_ERR: begin
            if (!dl_d) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ioctl_wait = req_q;
  assign mem_wr_req = req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign load_addr  = load_q;
  assign end_addr   = end_q;
`ifdef TAP_AUTOSTART_EN
  assign exec_req   = exec_req_q;
  assign exec_addr  = exec_addr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kc_tap_loader.sv
// tb_kc_tap_loader: directed self-checking bench for kc_tap_loader with a model write arbiter.
`default_nettype none

module tb_kc_tap_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr_req;
  logic        mem_wr_ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] load_addr;
  logic [15:0] end_addr;
`ifdef TAP_AUTOSTART_EN
  logic        exec_req;
  logic [15:0] exec_addr;
`endif

  kc_tap_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
    .busy(busy), .done(done), .error(error),
    .load_addr(load_addr), .end_addr(end_addr)
`ifdef TAP_AUTOSTART_EN
    , .exec_req(exec_req), .exec_addr(exec_addr)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Arbiter model state
  int          ack_delay = 1;
  int          req_cyc = 0;
  int          last_req_len = 0;
  int          wait_viol = 0;
  int          stab_viol = 0;
  bit          req_seen = 0;
  logic [15:0] hold_addr;
  logic [7:0]  hold_data;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          file_off = 0;
`ifdef TAP_AUTOSTART_EN
  int          exec_pulses = 0;
  logic [15:0] exec_seen = 16'd0;
  bit          exec_done_ok = 0;
  always @(negedge clk_sys) begin
    if (exec_req === 1'b1) begin
      exec_pulses++;
      exec_seen = exec_addr;
      exec_done_ok = (done === 1'b1);
    end
  end
`endif

  initial begin
    mem_wr_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      mem_wr_ack = 1'b0;
      if (ioctl_wait !== mem_wr_req) wait_viol++;
      if (mem_wr_req === 1'b1) begin
        req_seen = 1;
        if (req_cyc == 0) begin
          hold_addr = mem_addr;
          hold_data = mem_data;
        end else if (mem_addr !== hold_addr || mem_data !== hold_data) begin
          stab_viol++;
        end
        if (req_cyc == ack_delay) begin
          mem_wr_ack = 1'b1;
          wa.push_back(mem_addr);
          wd.push_back(mem_data);
          last_req_len = req_cyc + 1;
          req_cyc = 0;
        end else begin
          req_cyc++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pdata(input int i);
    logic [7:0] v;
    v = 8'hAA + 8'h11 * i[7:0];
    return v;
  endfunction

  function automatic logic [7:0] sigb(input int k);
    logic [127:0] s;
    s = 128'hC3_4B_43_2D_54_41_50_45_20_62_79_20_41_46_2E_20;
    return s[127 - 8*k -: 8];
  endfunction

  task automatic clear_log();
    wa.delete();
    wd.delete();
    req_seen = 0;
    wait_viol = 0;
    stab_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk_sys);
    ioctl_data = b;
    ioctl_addr = 25'(file_off);
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    file_off++;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL wait_timeout: observed=%0d cycles expected<200", n);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    file_off = 0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic send_sig(input int bad_pos, input logic [7:0] bad_val);
    for (int k = 0; k < 16; k++)
      send_byte((k == bad_pos) ? bad_val : sigb(k));
  endtask

  task automatic send_hdr(input logic [7:0] args, input logic [15:0] ld,
                          input logic [15:0] en, input logic [15:0] st);
    logic [7:0] b;
    send_byte(8'h01);
    for (int d = 0; d < 128; d++) begin
      case (d)
        16: b = args;
        17: b = ld[7:0];
        18: b = ld[15:8];
        19: b = en[7:0];
        20: b = en[15:8];
        21: b = st[7:0];
        22: b = st[15:8];
        default: b = (d < 11) ? 8'h41 + 8'(d) : 8'h00;
      endcase
      send_byte(b);
    end
  endtask

  task automatic send_payload(input int n, input int stop_after, input bit pad);
    int i;
    for (i = 0; i < n && i < stop_after; i++) begin
      if (i % 128 == 0) send_byte(8'(i / 128 + 2));
      send_byte(pdata(i));
    end
    if (pad && (n % 128 != 0))
      for (int p = 0; p < 128 - (n % 128); p++) send_byte(8'h00);
  endtask

  task automatic check_log(input string tag, input int n, input logic [15:0] base);
    int bad;
    bad = 0;
    check({tag, "_count"}, wa.size(), n);
    for (int i = 0; i < wa.size() && i < n; i++)
      if (wa[i] !== base + 16'(i) || wd[i] !== pdata(i)) bad++;
    check({tag, "_entries_bad"}, bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {busy, done, error, mem_wr_req, ioctl_wait}, 5'b0);
    check("reset_addrs", {mem_addr, load_addr}, 32'h0);
    check("reset_end_data", {end_addr, mem_data}, 24'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Valid 5-byte file
    clear_log();
    ack_delay = 1;
    start_dl(8'd1);
    check("t1_busy_at_start", busy, 1'b1);
    send_sig(-1, 8'h00);
    send_hdr(8'd2, 16'h0300, 16'h0305, 16'h0300);
    check("t1_load_addr", load_addr, 16'h0300);
    check("t1_end_addr", end_addr, 16'h0305);
    send_payload(5, 5, 1'b1);
    end_dl();
    check_log("t1", 5, 16'h0300);
    check("t1_done_err_busy", {done, error, busy}, 3'b100);
    check("t1_req_len", last_req_len, 2);
    check("t1_wait_eq_req", wait_viol, 0);

    // Bad signature byte 3
    clear_log();
    start_dl(8'd1);
    check("t2_done_cleared", done, 1'b0);
    send_sig(3, 8'h58);
    check("t2_error_after_byte", error, 1'b1);
    check("t2_busy", busy, 1'b0);
    for (int k = 4; k < 16; k++) send_byte(sigb(k));
    send_hdr(8'd2, 16'h0300, 16'h0305, 16'h0300);
    send_payload(5, 5, 1'b1);
    check("t2_error_sticky", error, 1'b1);
    end_dl();
    check("t2_no_req", req_seen, 1'b0);
    check("t2_wait_eq_req", wait_viol, 0);

    // Three-block payload
    clear_log();
    start_dl(8'd1);
    check("t3_error_cleared", error, 1'b0);
    send_sig(-1, 8'h00);
    send_hdr(8'd2, 16'h1000, 16'h112C, 16'h1000);
    send_payload(300, 300, 1'b1);
    end_dl();
    check_log("t3", 300, 16'h1000);
    check("t3_last_addr", (wa.size() > 0) ? 32'(wa[wa.size()-1]) : 32'hDEAD, 16'h112B);
    check("t3_done_err", {done, error}, 2'b10);

    // Slow arbiter
    clear_log();
    ack_delay = 20;
    start_dl(8'd1);
    send_sig(-1, 8'h00);
    send_hdr(8'd2, 16'h2000, 16'h2005, 16'h2000);
    send_payload(5, 5, 1'b1);
    end_dl();
    check_log("t4", 5, 16'h2000);
    check("t4_req_len", last_req_len, 21);
    check("t4_stable", stab_viol, 0);
    check("t4_wait_eq_req", wait_viol, 0);
    check("t4_done", done, 1'b1);
    ack_delay = 1;

    // Truncated after 2 payload bytes
    clear_log();
    start_dl(8'd1);
    send_sig(-1, 8'h00);
    send_hdr(8'd2, 16'h0300, 16'h0305, 16'h0300);
    send_payload(5, 2, 1'b0);
    end_dl();
    check_log("t5", 2, 16'h0300);
    check("t5_err_done", {error, done}, 2'b10);
    clear_log();
    start_dl(8'd1);
    check("t5_restart_err_clear", {error, busy}, 2'b01);
    send_sig(-1, 8'h00);
    send_hdr(8'd2, 16'h0300, 16'h0305, 16'h0300);
    send_payload(5, 5, 1'b1);
    end_dl();
    check_log("t5r", 5, 16'h0300);
    check("t5r_done_err", {done, error}, 2'b10);

    // Header rejects: arg_cnt=1, end==load, load=0xFFFF
    start_dl(8'd1);
    send_sig(-1, 8'h00);
    send_hdr(8'd1, 16'h0300, 16'h0305, 16'h0300);
    check("t6_args1_error", error, 1'b1);
    end_dl();
    start_dl(8'd1);
    send_sig(-1, 8'h00);
    send_hdr(8'd2, 16'h0400, 16'h0400, 16'h0400);
    check("t6_empty_error", error, 1'b1);
    end_dl();
    clear_log();
    start_dl(8'd1);
    send_sig(-1, 8'h00);
    send_hdr(8'd3, 16'hFFFF, 16'hFFFF, 16'h0000);
    send_payload(2, 2, 1'b1);
    check("t6_ffff_error", error, 1'b1);
    end_dl();
    check("t6_no_req", req_seen, 1'b0);

    // Foreign index ignored
    start_dl(8'd2);
    send_sig(-1, 8'h00);
    check("t7_other_index_idle", {busy, done, error}, 3'b001);
    end_dl();

`ifdef TAP_AUTOSTART_EN
    clear_log();
    exec_pulses = 0;
    start_dl(8'd1);
    send_sig(-1, 8'h00);
    send_hdr(8'd3, 16'h0300, 16'h0302, 16'h0310);
    send_payload(2, 2, 1'b1);
    end_dl();
    check("t8_exec_pulses", exec_pulses, 1);
    check("t8_exec_addr", exec_seen, 16'h0310);
    check("t8_exec_with_done", exec_done_ok, 1'b1);
    check("t8_exec_hold", exec_addr, 16'h0310);
    exec_pulses = 0;
    start_dl(8'd1);
    send_sig(-1, 8'h00);
    send_hdr(8'd2, 16'h0300, 16'h0302, 16'h0320);
    send_payload(2, 2, 1'b1);
    end_dl();
    check("t8_no_exec_args2", exec_pulses, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
